// File: rtl/cfo_track.sv
// Carrier-frequency-offset tracker: averages 2^LOG2_NAVG angle estimates into a
// per-sample phase increment and integrates it in a wrapping phase accumulator.
module cfo_track #(
   parameter int ZW        = 11,
   parameter int LOG2_NAVG = 2,
   parameter int LOG2_NFFT = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [ZW-1:0] ang_in,
   input  logic          ang_vld,
   input  logic          samp_vld,
   output logic [ZW-1:0] avg_out,
   output logic          avg_vld,
   output logic [ZW-1:0] phase_out,
   output logic          locked
);

   localparam int SW = ZW + LOG2_NAVG;
   localparam int PW = ZW + 1 + LOG2_NFFT;
   localparam logic signed [PW:0] PI_F     = (PW+1)'(804  * (2 ** LOG2_NFFT));
   localparam logic signed [PW:0] TWO_PI_F = (PW+1)'(1608 * (2 ** LOG2_NFFT));

   typedef enum logic [1:0] {IDLE, ACC, UPD} state_t;

   state_t                 state;
   logic signed [SW-1:0]   sum;
   logic [LOG2_NAVG-1:0]   cnt;
   logic signed [PW-1:0]   inc;
   logic signed [PW-1:0]   acc;

   logic signed [SW-1:0]   ang_ext;
   logic signed [ZW-1:0]   avg_q;
   logic signed [PW:0]     s;
   logic signed [PW:0]     s_wrap;

   always_comb begin
      ang_ext = {{LOG2_NAVG{ang_in[ZW-1]}}, ang_in};
      // Upper ZW bits of sum are exactly sum >>> LOG2_NAVG (floor division).
      avg_q   = sum[SW-1:LOG2_NAVG];
      s       = {acc[PW-1], acc} + {inc[PW-1], inc};
      s_wrap  = s;
      if (s > PI_F)
         s_wrap = s - TWO_PI_F;
      else if (s < -PI_F)
         s_wrap = s + TWO_PI_F;
   end

   // Arithmetic shift of acc by LOG2_NFFT, truncated to ZW bits.
   assign phase_out = acc[ZW-1+LOG2_NFFT:LOG2_NFFT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sum     <= '0;
         cnt     <= '0;
         inc     <= '0;
         acc     <= '0;
         avg_out <= '0;
         avg_vld <= 1'b0;
         locked  <= 1'b0;
      end else if (clr) begin
         state   <= IDLE;
         sum     <= '0;
         cnt     <= '0;
         inc     <= '0;
         acc     <= '0;
         avg_out <= '0;
         avg_vld <= 1'b0;
         locked  <= 1'b0;
      end else begin
         avg_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (ang_vld) begin
                  sum   <= ang_ext;
                  cnt   <= LOG2_NAVG'(1);
                  state <= ACC;
               end
            end
            ACC: begin
               if (ang_vld) begin
                  sum <= sum + ang_ext;
                  cnt <= cnt + 1'b1;
                  if (cnt == '1)
                     state <= UPD;
               end
            end
            UPD: begin
               avg_out <= avg_q;
               inc     <= {{(PW-ZW){avg_q[ZW-1]}}, avg_q};
               avg_vld <= 1'b1;
               locked  <= 1'b1;
               // A sample arriving during the update opens the next window.
               if (ang_vld) begin
                  sum   <= ang_ext;
                  cnt   <= LOG2_NAVG'(1);
                  state <= ACC;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (locked && samp_vld)
            acc <= s_wrap[PW-1:0];
      end
   end

endmodule

// File: tb/tb_cfo_track.sv
// Scoreboard bench for cfo_track: expected averages are queued as windows
// complete and matched, value and cycle, against each avg_vld pulse.
module tb_cfo_track;
   localparam int ZW        = 11;
   localparam int LOG2_NAVG = 2;
   localparam int LOG2_NFFT = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic [ZW-1:0] ang_in;
   logic          ang_vld;
   logic          samp_vld;
   logic [ZW-1:0] avg_out;
   logic          avg_vld;
   logic [ZW-1:0] phase_out;
   logic          locked;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   mon_got;
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;
   int   m_sum  = 0;
   int   m_n    = 0;
   int   got;

   cfo_track #(.ZW(ZW), .LOG2_NAVG(LOG2_NAVG), .LOG2_NFFT(LOG2_NFFT)) dut (
      .clk(clk), .rst(rst), .clr(clr), .ang_in(ang_in), .ang_vld(ang_vld),
      .samp_vld(samp_vld), .avg_out(avg_out), .avg_vld(avg_vld),
      .phase_out(phase_out), .locked(locked)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Scoreboard: every avg_vld pulse must match the oldest queued window.
   always @(negedge clk) begin
      if (rst === 1'b1 && avg_vld === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL avg_vld_unexpected cycle=%0d got pulse avg_out=%0d required no pulse",
                     cyc_n, $signed(avg_out));
         end else begin
            mon_e   = q.pop_front();
            mon_got = $signed(avg_out);
            if (mon_got !== mon_e.val || cyc_n !== mon_e.cyc) begin
               errors++;
               $display("FAIL avg_pulse got avg=%0d cycle=%0d required avg=%0d cycle=%0d",
                        mon_got, cyc_n, mon_e.val, mon_e.cyc);
            end
         end
      end
   end

   // Drive one cycle of stimulus and update the window model.
   task automatic tick(input logic v, input int a, input logic s, input logic c);
      ang_vld  = v;
      ang_in   = ZW'(a);
      samp_vld = s;
      clr      = c;
      if (c) begin
         m_sum = 0;
         m_n   = 0;
      end else if (v) begin
         m_sum += a;
         m_n++;
         if (m_n == (1 << LOG2_NAVG)) begin
            q.push_back('{m_sum >>> LOG2_NAVG, cyc_n + 2});
            m_sum = 0;
            m_n   = 0;
         end
      end
      @(negedge clk);
      ang_vld  = 1'b0;
      samp_vld = 1'b0;
      clr      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b0; clr = 1'b0; ang_vld = 1'b0; samp_vld = 1'b0; ang_in = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (avg_out !== '0 || avg_vld !== 1'b0 || phase_out !== '0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got avg=%0d vld=%b phase=%0d locked=%b required all 0",
                  avg_out, avg_vld, phase_out, locked);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_average;
      tick(1'b1, 100, 1'b0, 1'b0);
      tick(1'b0, 0, 1'b0, 1'b0);
      tick(1'b1, 104, 1'b0, 1'b0);
      idle(2);
      tick(1'b1, 108, 1'b0, 1'b0);
      tick(1'b1, 112, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0 || avg_vld !== 1'b0) begin
         errors++;
         $display("FAIL avg_early got locked=%b vld=%b required 0 0", locked, avg_vld);
      end
      idle(1);
      got = $signed(avg_out);
      checks++;
      if (got !== 106 || locked !== 1'b1 || avg_vld !== 1'b1) begin
         errors++;
         $display("FAIL avg_value got avg=%0d locked=%b vld=%b required 106 1 1", got, locked, avg_vld);
      end
      idle(1);
      checks++;
      if (avg_vld !== 1'b0) begin
         errors++;
         $display("FAIL avg_pulse_width got vld=%b required 0", avg_vld);
      end
   endtask

   task automatic test_negative_floor;
      tick(1'b1, -1, 1'b0, 1'b0);
      tick(1'b1, -2, 1'b0, 1'b0);
      tick(1'b1, -2, 1'b0, 1'b0);
      tick(1'b1, -2, 1'b0, 1'b0);
      idle(2);
      got = $signed(avg_out);
      checks++;
      if (got !== -2) begin
         errors++;
         $display("FAIL neg_floor got avg=%0d required -2", got);
      end
   endtask

   task automatic test_accumulate_wrap;
      tick(1'b0, 0, 1'b0, 1'b1);
      repeat (3) tick(1'b0, 0, 1'b1, 1'b0);
      checks++;
      if (phase_out !== '0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL unlocked_hold got phase=%0d locked=%b required 0 0", phase_out, locked);
      end
      repeat (4) tick(1'b1, 64, 1'b0, 1'b0);
      idle(2);
      repeat (63) tick(1'b0, 0, 1'b1, 1'b0);
      got = $signed(phase_out);
      checks++;
      if (got !== 63) begin
         errors++;
         $display("FAIL phase_63 got phase=%0d required 63", got);
      end
      tick(1'b0, 0, 1'b1, 1'b0);
      got = $signed(phase_out);
      checks++;
      if (got !== 64) begin
         errors++;
         $display("FAIL phase_64 got phase=%0d required 64", got);
      end

      tick(1'b0, 0, 1'b0, 1'b1);
      repeat (4) tick(1'b1, 402, 1'b0, 1'b0);
      idle(2);
      repeat (127) tick(1'b0, 0, 1'b1, 1'b0);
      got = $signed(phase_out);
      checks++;
      if (got !== 797) begin
         errors++;
         $display("FAIL phase_127 got phase=%0d required 797", got);
      end
      tick(1'b0, 0, 1'b1, 1'b0);
      got = $signed(phase_out);
      checks++;
      if (got !== 804) begin
         errors++;
         $display("FAIL phase_pi_nowrap got phase=%0d required 804", got);
      end
      tick(1'b0, 0, 1'b1, 1'b0);
      got = $signed(phase_out);
      checks++;
      if (got !== -798) begin
         errors++;
         $display("FAIL phase_wrap got phase=%0d required -798", got);
      end
      idle(2);
      got = $signed(phase_out);
      checks++;
      if (got !== -798) begin
         errors++;
         $display("FAIL phase_hold got phase=%0d required -798", got);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 1; i <= 8; i++)
         tick(1'b1, 10 * i, 1'b0, 1'b0);
      idle(3);
      got = $signed(avg_out);
      checks++;
      if (got !== 65 || q.size() != 0) begin
         errors++;
         $display("FAIL back_to_back got avg=%0d pending=%0d required 65 0", got, q.size());
      end
   endtask

   task automatic test_clr_mid_window;
      tick(1'b1, 5, 1'b0, 1'b0);
      tick(1'b1, 7, 1'b0, 1'b0);
      tick(1'b1, 99, 1'b1, 1'b1);
      checks++;
      if (locked !== 1'b0 || avg_out !== '0 || phase_out !== '0 || avg_vld !== 1'b0) begin
         errors++;
         $display("FAIL clr_state got locked=%b avg=%0d phase=%0d vld=%b required all 0",
                  locked, avg_out, phase_out, avg_vld);
      end
      tick(1'b1, 20, 1'b0, 1'b0);
      tick(1'b1, 20, 1'b0, 1'b0);
      tick(1'b1, 24, 1'b0, 1'b0);
      tick(1'b1, 24, 1'b0, 1'b0);
      idle(2);
      got = $signed(avg_out);
      checks++;
      if (got !== 22 || locked !== 1'b1) begin
         errors++;
         $display("FAIL clr_recover got avg=%0d locked=%b required 22 1", got, locked);
      end
   endtask

   task automatic test_reset_mid_window;
      repeat (5) tick(1'b0, 0, 1'b1, 1'b0);
      got = $signed(phase_out);
      checks++;
      if (got !== 1) begin
         errors++;
         $display("FAIL pre_reset_phase got phase=%0d required 1", got);
      end
      tick(1'b1, 50, 1'b0, 1'b0);
      tick(1'b1, 60, 1'b0, 1'b0);
      #2 rst = 1'b0;
      m_sum = 0;
      m_n   = 0;
      q.delete();
      #1;
      checks++;
      if (avg_out !== '0 || avg_vld !== 1'b0 || phase_out !== '0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got avg=%0d vld=%b phase=%0d locked=%b required all 0",
                  avg_out, avg_vld, phase_out, locked);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick(1'b1, 30, 1'b0, 1'b0);
      idle(3);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard got locked=%b required 0", locked);
      end
      tick(1'b1, 30, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL reset_latency got locked=%b required 0", locked);
      end
      idle(1);
      got = $signed(avg_out);
      checks++;
      if (locked !== 1'b1 || got !== 30) begin
         errors++;
         $display("FAIL reset_relock got locked=%b avg=%0d required 1 30", locked, got);
      end
      idle(2);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got pending=%0d required 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_average();
      test_negative_floor();
      test_accumulate_wrap();
      test_back_to_back();
      test_clr_mid_window();
      test_reset_mid_window();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cfo_track.md
# cfo_track

Carrier-frequency-offset tracking stage placed directly downstream of the CORDIC angle block. It accepts the per-symbol correlation angle, averages 2^LOG2_NAVG estimates, and turns the average into a per-sample correction increment. A wrapping phase accumulator then produces the running phase that the derotator consumes.

## Interface

Parameters:
- ZW, 11: angle width. Signed raw radians with 8 fraction bits; matches ang_t.
- LOG2_NAVG, 2: log2 of the number of estimates averaged. Must be ≥ 1.
- LOG2_NFFT, 6: log2 of the correlation lag in samples. Sets the extra fraction bits of the phase accumulator.

Ports:
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- clr, in, 1: synchronous clear.
- ang_in, in, ZW: signed angle estimate.
- ang_vld, in, 1: ang_in is valid this cycle. Single-cycle strobe, at most one per cycle.
- samp_vld, in, 1: sample strobe; advances the phase accumulator.
- avg_out, out, ZW: latest averaged angle.
- avg_vld, out, 1: one-cycle pulse when avg_out updates.
- phase_out, out, ZW: accumulated correction phase, same Q-format as ang_in.
- locked, out, 1: at least one average has completed since the last reset or clr.

## Operation

- Internal registers:
  - sum: ZW+LOG2_NAVG bits, signed.
  - cnt: LOG2_NAVG bits.
  - inc: PW bits, signed.
  - acc: PW bits, signed, where PW = ZW+1+LOG2_NFFT.
- FSM states: IDLE, ACC, UPD.
  - IDLE: on ang_vld, sum ← sext(ang_in), cnt ← 1, go to ACC.
  - ACC: on ang_vld, sum ← sum + ang_in, cnt ← cnt+1.
    - If this sample is the 2^LOG2_NAVG-th (cnt = 2^LOG2_NAVG−1 before the update), go to UPD.
    - Without ang_vld, stay in ACC.
  - UPD: lasts one cycle.
    - avg_out ← sum >>> LOG2_NAVG (arithmetic, floor).
    - inc ← sext(sum >>> LOG2_NAVG) to PW.
    - avg_vld ← 1 for one cycle; locked ← 1.
    - If ang_vld is high in UPD, that sample starts the next window: sum ← ang_in, cnt ← 1, go to ACC. Otherwise go to IDLE. No sample is ever dropped.
- Phase accumulator:
  - Constants: PI_F = 804·2^LOG2_NFFT, 2PI_F = 1608·2^LOG2_NFFT.
  - When locked and samp_vld: s = acc + inc.
    - If s > PI_F, acc ← s − 2PI_F.
    - Else if s < −PI_F, acc ← s + 2PI_F.
    - Else acc ← s.
  - Exactly ±PI_F does not wrap.
  - When not locked, acc holds at 0.
  - phase_out = acc >>> LOG2_NFFT, arithmetic, truncated to ZW bits.
  - The downstream derotator applies −phase_out.
- clr:
  - Priority over everything. It forces IDLE and sets sum, cnt, inc, acc, avg_out, avg_vld and locked to 0.
  - An ang_vld or samp_vld coinciding with clr is discarded.
- All arithmetic is two's complement. sum cannot overflow at its declared width.

## Timing

- Reset (rst=0, asynchronous): immediately sets all outputs to 0 (avg_out, avg_vld, phase_out, locked) and the FSM to IDLE. Release is synchronous to clk.
- Averaging latency: last ang_vld of a window in cycle c → UPD in cycle c+1 → avg_out, avg_vld and locked visible in cycle c+2.
- Back-to-back ang_vld (every cycle) is sustained indefinitely. avg_vld then pulses every 2^LOG2_NAVG cycles.
- New inc takes effect on the first samp_vld after the cycle in which avg_vld is high. A samp_vld at the UPD edge uses the old inc.
- phase_out changes one cycle after a sampled samp_vld (registered acc).

## Test plan

1. **Reset:** assert rst mid-window with sum ≠ 0 and locked = 1 → all outputs read 0 in the same cycle, FSM in IDLE. After release, a clean window of 4 estimates is required before locked = 1.
2. **Average:** LOG2_NAVG = 2, ang_vld with 100, 104, 108, 112 in cycles 0, 2, 5, 6 → avg_out = 106 and avg_vld high only in cycle 8; locked rises in cycle 8.
3. **Negative floor:** inputs −1, −2, −2, −2 → sum = −7, avg_out = −2.
4. **Accumulation and wrap:** LOG2_NFFT = 6, avg = 64 → after 64 samp_vld, phase_out = 64. With avg = 402:
   - after 128 samp_vld, acc = 51456 and phase_out = 804 (no wrap);
   - the 129th samp_vld gives acc = −51054 and phase_out = −798.
5. **Continuous ang_vld:** 8 consecutive cycles starting in cycle 0 → avg_vld pulses in cycles 5 and 9. The sample in UPD (cycle 4) is counted in window 2.
6. **clr mid-window:** 2 samples, then clr together with ang_vld → that sample is dropped and locked = 0. The next 4 samples (20, 20, 24, 24) give avg_out = 22.
